// File: rtl/ingress_fifo_writer.sv
// ingress_fifo_writer
//
// Ingress buffer writer for one switch port. AXI-stream frames (32- or 64-bit
// beats) are packed into 64-bit words of a single-port buffer RAM. Each frame
// gets a reserved header slot in front of its data; the header (VLAN, byte
// length) is written last and the frame is then published to the reader by
// advancing wr_ptr_committed. Frames that run out of space, grow past
// MAX_FRAME or end with an error flag are dropped whole and counted; the
// input side never stalls in the middle of a frame.
//
// Ports:
//   clk, rst          fabric clock, synchronous active-high reset
//   rx_tvalid/tready  AXI-stream handshake (tready drops only for the header cycle)
//   rx_tdata/tstrb    beat data and contiguous-from-LSB byte strobes
//   rx_tlast          last beat of a frame
//   rx_tuser          frame error flag, sampled with tlast
//   rx_tdest          VLAN ID, sampled with tlast
//   wr_en/addr/data   RAM write port (wr_data[71:64] always zero)
//   wr_ptr_committed  word pointer just past the last committed frame
//   rd_ptr            reader's word pointer
//   drop_err/ovf/big  wrapping per-cause drop counters
module ingress_fifo_writer #(
  parameter int IN_BYTES  = 4,
  parameter int DEPTH     = 4096,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int MAX_FRAME = 1522
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_tvalid,
  output logic                   rx_tready,
  input  logic [8*IN_BYTES-1:0]  rx_tdata,
  input  logic [IN_BYTES-1:0]    rx_tstrb,
  input  logic                   rx_tlast,
  input  logic                   rx_tuser,
  input  logic [11:0]            rx_tdest,
  output logic                   wr_en,
  output logic [ADDR_BITS-1:0]   wr_addr,
  output logic [71:0]            wr_data,
  output logic [ADDR_BITS:0]     wr_ptr_committed,
  input  logic [ADDR_BITS:0]     rd_ptr,
  output logic [31:0]            drop_err,
  output logic [31:0]            drop_ovf,
  output logic [31:0]            drop_big
);

  localparam int PW = ADDR_BITS + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DATA    = 2'd1;
  localparam logic [1:0] ST_HEADER  = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
  localparam logic [14:0] MAX_W   = 15'(MAX_FRAME);

  // Number of valid bytes in a beat.
  function automatic logic [3:0] strb_count(input logic [IN_BYTES-1:0] s);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < IN_BYTES; i++) begin
      n = n + {3'd0, s[i]};
    end
    return n;
  endfunction

  // Zero the bytes whose strobe is clear and widen the beat to 64 bits.
  function automatic logic [63:0] mask_beat(input logic [8*IN_BYTES-1:0] d,
                                            input logic [IN_BYTES-1:0]   s);
    logic [63:0] m;
    m = 64'd0;
    for (int i = 0; i < IN_BYTES; i++) begin
      m[8*i +: 8] = s[i] ? d[8*i +: 8] : 8'd0;
    end
    return m;
  endfunction

  // State and datapath flops
  logic [1:0]           state_q, state_d;
  logic                 tready_q, tready_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        sof_ptr_q, sof_ptr_d;
  logic [PW-1:0]        committed_q, committed_d;
  logic [13:0]          frame_len_q, frame_len_d;
  logic [11:0]          vlan_q, vlan_d;
  logic                 half_q, half_d;
  logic [31:0]          lo_q, lo_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [71:0]          wr_data_q, wr_data_d;
  logic [31:0]          drop_err_q, drop_err_d;
  logic [31:0]          drop_ovf_q, drop_ovf_d;
  logic [31:0]          drop_big_q, drop_big_d;

  // Per-beat analysis
  logic                 beat_ok_s;
  logic                 is_idle_s;
  logic [PW-1:0]        base_ptr_s;
  logic [PW-1:0]        base_sof_s;
  logic [13:0]          len_base_s;
  logic                 half_base_s;
  logic [14:0]          len_sum_s;
  logic [63:0]          beat_s;
  logic [63:0]          word_s;
  logic                 word_done_s;
  logic [PW-1:0]        used_idle_s;
  logic [PW-1:0]        used_s;
  logic                 ovf_s;
  logic                 big_s;
  logic                 err_s;

  assign rx_tready        = tready_q;
  assign wr_en            = wr_en_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign wr_ptr_committed = committed_q;
  assign drop_err         = drop_err_q;
  assign drop_ovf         = drop_ovf_q;
  assign drop_big         = drop_big_q;

  // Classify the current beat: packing, length, space and error checks.
  always_comb begin
    beat_ok_s = rx_tvalid & tready_q;
    is_idle_s = (state_q == ST_IDLE);
    // A frame's first beat is seen in IDLE: the header slot at wr_ptr is
    // reserved, so its data lands one word further on.
    base_ptr_s  = is_idle_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    base_sof_s  = is_idle_s ? wr_ptr_q : sof_ptr_q;
    len_base_s  = is_idle_s ? 14'd0 : frame_len_q;
    half_base_s = is_idle_s ? 1'b0 : half_q;
    // 15-bit sum so a large frame cannot wrap past the MAX_FRAME check.
    len_sum_s   = {1'b0, len_base_s} + {11'd0, strb_count(rx_tstrb)};
    beat_s      = mask_beat(rx_tdata, rx_tstrb);
    if (IN_BYTES == 8) begin
      word_s      = beat_s;
      word_done_s = 1'b1;
    end else begin
      if (half_base_s) begin
        word_s = {beat_s[31:0], lo_q};
      end else begin
        word_s = {32'd0, beat_s[31:0]};
      end
      word_done_s = half_base_s | rx_tlast;
    end
    used_idle_s = wr_ptr_q - rd_ptr;
    used_s      = base_ptr_s - rd_ptr;
    // A new frame needs room for its header plus at least one data word.
    if (is_idle_s) begin
      ovf_s = (({1'b0, used_idle_s} + (PW+1)'(2)) > DEPTH_W);
    end else begin
      ovf_s = word_done_s & ({1'b0, used_s} >= DEPTH_W);
    end
    big_s = (len_sum_s > MAX_W);
    err_s = rx_tlast & rx_tuser;
  end

  // Next-state logic for the frame FSM, RAM write port and counters.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    sof_ptr_d   = sof_ptr_q;
    committed_d = committed_q;
    frame_len_d = frame_len_q;
    vlan_d      = vlan_q;
    half_d      = half_q;
    lo_d        = lo_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    drop_err_d  = drop_err_q;
    drop_ovf_d  = drop_ovf_q;
    drop_big_d  = drop_big_q;

    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (beat_ok_s) begin
          // Drop causes are mutually exclusive: overflow > big > error.
          if (ovf_s) begin
            drop_ovf_d = drop_ovf_q + 32'd1;
            wr_ptr_d   = base_sof_s;
            half_d     = 1'b0;
            state_d    = rx_tlast ? ST_IDLE : ST_DISCARD;
          end else if (big_s) begin
            drop_big_d = drop_big_q + 32'd1;
            wr_ptr_d   = base_sof_s;
            half_d     = 1'b0;
            state_d    = rx_tlast ? ST_IDLE : ST_DISCARD;
          end else if (err_s) begin
            drop_err_d = drop_err_q + 32'd1;
            wr_ptr_d   = base_sof_s;
            half_d     = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            sof_ptr_d   = base_sof_s;
            frame_len_d = len_sum_s[13:0];
            if (word_done_s) begin
              wr_en_d   = 1'b1;
              wr_addr_d = base_ptr_s[ADDR_BITS-1:0];
              wr_data_d = {8'd0, word_s};
              wr_ptr_d  = base_ptr_s + PW'(1);
              half_d    = 1'b0;
            end else begin
              lo_d     = beat_s[31:0];
              half_d   = 1'b1;
              wr_ptr_d = base_ptr_s;
            end
            if (rx_tlast) begin
              vlan_d  = rx_tdest;
              state_d = ST_HEADER;
            end else begin
              state_d = ST_DATA;
            end
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_HEADER: begin
        // Header goes into the reserved slot; the commit pointer moves on the
        // same edge so the reader never sees a frame without its header.
        wr_en_d     = 1'b1;
        wr_addr_d   = sof_ptr_q[ADDR_BITS-1:0];
        wr_data_d   = {44'd0, vlan_q, 2'd0, frame_len_q};
        committed_d = wr_ptr_q;
        state_d     = ST_IDLE;
      end
      ST_DISCARD: begin
        if (beat_ok_s && rx_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        half_d  = 1'b0;
      end
    endcase

    tready_d = (state_d != ST_HEADER);
  end

  // Register update with synchronous reset; a reset mid-frame discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tready_q    <= 1'b1;
      wr_ptr_q    <= '0;
      sof_ptr_q   <= '0;
      committed_q <= '0;
      frame_len_q <= 14'd0;
      vlan_q      <= 12'd0;
      half_q      <= 1'b0;
      lo_q        <= 32'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 72'd0;
      drop_err_q  <= 32'd0;
      drop_ovf_q  <= 32'd0;
      drop_big_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      wr_ptr_q    <= wr_ptr_d;
      sof_ptr_q   <= sof_ptr_d;
      committed_q <= committed_d;
      frame_len_q <= frame_len_d;
      vlan_q      <= vlan_d;
      half_q      <= half_d;
      lo_q        <= lo_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      drop_err_q  <= drop_err_d;
      drop_ovf_q  <= drop_ovf_d;
      drop_big_q  <= drop_big_d;
    end
  end

endmodule

// File: tb/tb_ingress_fifo_writer.sv
// Testbench for ingress_fifo_writer. Two instances: u_big (DEPTH 4096) and
// u_small (DEPTH 16), both IN_BYTES=4, MAX_FRAME=1522. Only the instance
// selected by 'sel' sees valid beats. Expected RAM writes are queued when a
// frame is driven and popped as the selected DUT writes.
module tb_ingress_fifo_writer;

  typedef struct {
    int sel;
    int rd;
    int len;
    int vlan;
    int tuser;
    int zt;
    int good;
    int exp_comm;
    int exp_err;
    int exp_big;
    int exp_ovf;
  } rec_t;

  typedef struct {
    logic [11:0] addr;
    logic [71:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        tvalid = 1'b0;
  logic [31:0] tdata = 32'd0;
  logic [3:0]  tstrb = 4'd0;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;
  logic [11:0] tdest = 12'd0;
  logic [12:0] rd_a = 13'd0;
  logic [4:0]  rd_b = 5'd0;

  logic        a_tready, a_wr_en;
  logic [11:0] a_wr_addr;
  logic [71:0] a_wr_data;
  logic [12:0] a_comm;
  logic [31:0] a_err, a_ovf, a_big;
  logic        b_tready, b_wr_en;
  logic [3:0]  b_wr_addr;
  logic [71:0] b_wr_data;
  logic [4:0]  b_comm;
  logic [31:0] b_err, b_ovf, b_big;

  logic        m_tready, m_wr_en;
  logic [11:0] m_wr_addr;
  logic [71:0] m_wr_data;
  logic [12:0] m_comm;
  logic [31:0] m_err, m_ovf, m_big;

  int   n_checks = 0;
  int   n_fail = 0;
  int   stalls;
  int   model_ptr [2];
  logic sb_ignore = 1'b0;
  wr_t  sb_q [$];
  rec_t tbl [15];
  rec_t rrec;

  always #5 clk = ~clk;

  ingress_fifo_writer #(.IN_BYTES(4), .DEPTH(4096), .MAX_FRAME(1522)) u_big (
    .clk(clk), .rst(rst), .rx_tvalid(tvalid & ~sel), .rx_tready(a_tready),
    .rx_tdata(tdata), .rx_tstrb(tstrb), .rx_tlast(tlast), .rx_tuser(tuser),
    .rx_tdest(tdest), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_ptr_committed(a_comm), .rd_ptr(rd_a), .drop_err(a_err),
    .drop_ovf(a_ovf), .drop_big(a_big));

  ingress_fifo_writer #(.IN_BYTES(4), .DEPTH(16), .MAX_FRAME(1522)) u_small (
    .clk(clk), .rst(rst), .rx_tvalid(tvalid & sel), .rx_tready(b_tready),
    .rx_tdata(tdata), .rx_tstrb(tstrb), .rx_tlast(tlast), .rx_tuser(tuser),
    .rx_tdest(tdest), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_ptr_committed(b_comm), .rd_ptr(rd_b), .drop_err(b_err),
    .drop_ovf(b_ovf), .drop_big(b_big));

  assign m_tready  = sel ? b_tready : a_tready;
  assign m_wr_en   = sel ? b_wr_en : a_wr_en;
  assign m_wr_addr = sel ? {8'd0, b_wr_addr} : a_wr_addr;
  assign m_wr_data = sel ? b_wr_data : a_wr_data;
  assign m_comm    = sel ? {8'd0, b_comm} : a_comm;
  assign m_err     = sel ? b_err : a_err;
  assign m_ovf     = sel ? b_ovf : a_ovf;
  assign m_big     = sel ? b_big : a_big;

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: advance past the edge, then score any RAM write.
  task automatic cyc();
    wr_t e;
    @(posedge clk);
    #1;
    if (m_wr_en && !sb_ignore) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", m_wr_addr, m_wr_data);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr", 72'(m_wr_addr), 72'(e.addr));
        check("wr_data", m_wr_data, e.data);
      end
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                           input logic u, input logic [11:0] v);
    logic r;
    logic done;
    tvalid = 1'b1; tdata = d; tstrb = s; tlast = l; tuser = u; tdest = v;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      r = m_tready;
      cyc();
      if (r) done = 1'b1;
      else stalls++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout: beat not accepted within 20 cycles, expected acceptance");
    end
  endtask

  function automatic int n_beats(input int len, input int zt);
    return (len + 3) / 4 + zt;
  endfunction

  task automatic send_frame(input int len, input int vlan, input int usr, input int zt,
                            input int nb_limit);
    int nb;
    logic [31:0] d;
    logic [3:0]  s;
    logic [7:0]  seed;
    seed = 8'(len + vlan);
    nb = n_beats(len, zt);
    if (nb_limit > 0 && nb_limit < nb) nb = nb_limit;
    stalls = 0;
    for (int b = 0; b < nb; b++) begin
      d = 32'd0;
      s = 4'd0;
      for (int j = 0; j < 4; j++) begin
        if (4*b + j < len) begin
          d[8*j +: 8] = 8'(seed + 8'(4*b + j));
          s[j] = 1'b1;
        end
      end
      send_beat(d, s, (b == n_beats(len, zt) - 1), (b == n_beats(len, zt) - 1) ? usr[0] : 1'b0,
                12'(vlan));
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  // Queue the data words and header a good frame should produce.
  task automatic push_expect(input int len, input int vlan, input int zt, input int s_sel);
    int   nw, sof, mask;
    wr_t  w;
    logic [7:0] seed;
    seed = 8'(len + vlan);
    mask = s_sel ? 15 : 4095;
    sof  = model_ptr[s_sel];
    nw   = (n_beats(len, zt) + 1) / 2;
    for (int j = 0; j < nw; j++) begin
      w.addr = 12'((sof + 1 + j) & mask);
      w.data = 72'd0;
      for (int k = 0; k < 8; k++) begin
        if (8*j + k < len) w.data[8*k +: 8] = 8'(seed + 8'(8*j + k));
      end
      sb_q.push_back(w);
    end
    w.addr = 12'(sof & mask);
    w.data = {44'd0, 12'(vlan), 2'd0, 14'(len)};
    sb_q.push_back(w);
    model_ptr[s_sel] = sof + nw + 1;
  endtask

  task automatic run_rec(input rec_t r);
    sel = r.sel[0];
    if (r.sel != 0) rd_b = 5'(r.rd);
    else rd_a = 13'(r.rd);
    if (r.good != 0) push_expect(r.len, r.vlan, r.zt, r.sel);
    else sb_ignore = 1'b1;
    send_frame(r.len, r.vlan, r.tuser, r.zt, 0);
    check("no_stall", 72'(stalls), 72'd0);
    if (r.good != 0) begin
      check("tready_header_cycle", 72'(m_tready), 72'd0);
      cyc();
      check("tready_after_header", 72'(m_tready), 72'd1);
    end
    repeat (3) cyc();
    sb_ignore = 1'b0;
    check("committed", 72'(m_comm), 72'(r.exp_comm));
    check("drop_err", 72'(m_err), 72'(r.exp_err));
    check("drop_big", 72'(m_big), 72'(r.exp_big));
    check("drop_ovf", 72'(m_ovf), 72'(r.exp_ovf));
    check("sb_drained", 72'(sb_q.size()), 72'd0);
  endtask

  initial begin
    //          sel rd  len  vlan  usr zt good comm err big ovf
    tbl[0]  = '{0, 0,   64,    5, 0, 0, 1,   9, 0, 0, 0};
    tbl[1]  = '{0, 0,   61,    7, 0, 0, 1,  18, 0, 0, 0};
    tbl[2]  = '{0, 0,   64,    3, 1, 0, 0,  18, 1, 0, 0};
    tbl[3]  = '{0, 0,   64,    9, 0, 0, 1,  27, 1, 0, 0};
    tbl[4]  = '{0, 0, 1600,    1, 0, 0, 0,  27, 1, 1, 0};
    tbl[5]  = '{0, 0,    8, 4095, 0, 0, 1,  29, 1, 1, 0};
    tbl[6]  = '{0, 0,    4,    2, 0, 0, 1,  31, 1, 1, 0};
    tbl[7]  = '{0, 0,   13, 2048, 0, 0, 1,  34, 1, 1, 0};
    tbl[8]  = '{0, 0,   12,    6, 0, 1, 1,  37, 1, 1, 0};
    tbl[9]  = '{1, 0,  200,   10, 0, 0, 0,   0, 0, 0, 1};
    tbl[10] = '{1, 0,   64,   11, 0, 0, 1,   9, 0, 0, 1};
    tbl[11] = '{1, 0,   64,   12, 0, 0, 0,   9, 0, 0, 2};
    tbl[12] = '{1, 9,   64,   13, 0, 0, 1,  18, 0, 0, 2};
    tbl[13] = '{1, 3,    8,   14, 0, 0, 0,  18, 0, 0, 3};
    tbl[14] = '{1, 4,    8,   15, 0, 0, 1,  20, 0, 0, 3};
    model_ptr[0] = 0;
    model_ptr[1] = 0;

    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    check("rst_tready", 72'(a_tready), 72'd1);
    check("rst_wr_en", 72'(a_wr_en), 72'd0);
    check("rst_wr_addr", 72'(a_wr_addr), 72'd0);
    check("rst_wr_data", a_wr_data, 72'd0);
    check("rst_committed", 72'(a_comm), 72'd0);
    check("rst_drop_err", 72'(a_err), 72'd0);
    check("rst_drop_ovf", 72'(a_ovf), 72'd0);
    check("rst_drop_big", 72'(a_big), 72'd0);

    for (int i = 0; i < 15; i++) begin
      run_rec(tbl[i]);
    end

    // Reset in the middle of a frame, then a clean 64-byte frame.
    sel = 1'b0;
    rd_a = 13'd0;
    sb_ignore = 1'b1;
    send_frame(64, 21, 0, 0, 5);
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    sb_q.delete();
    sb_ignore = 1'b0;
    model_ptr[0] = 0;
    check("mid_rst_drop_err", 72'(a_err), 72'd0);
    check("mid_rst_drop_big", 72'(a_big), 72'd0);
    check("mid_rst_drop_ovf", 72'(a_ovf), 72'd0);
    check("mid_rst_committed", 72'(a_comm), 72'd0);
    check("mid_rst_tready", 72'(a_tready), 72'd1);
    rrec = '{0, 0, 64, 5, 0, 0, 1, 9, 0, 0, 0};
    run_rec(rrec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
